// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the PC sequencer: FSM state encoding, next-PC source
// selector, default PC geometry and a saturating 16-bit increment helper.
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int          PC_W_DEF     = 7;
   localparam int unsigned RESET_PC_DEF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_INC  = 2'd0,
      SRC_JMP  = 2'd1,
      SRC_BR   = 2'd2,
      SRC_HOLD = 2'd3
   } pc_src_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/control_pc_if.sv
// ---------------------------------------------------------------------------
// control_pc_if
// Bundle between the hazard/branch logic (master) and the PC sequencer
// (slave).
//   master drives : start, stall, jump, jump_target, branch_taken,
//                   branch_target, halt_id
//   slave drives  : pc, pc_plus1, fetch_valid, flush_if_id, flush_id_ex,
//                   halted, fetch_count, dbg_state
// Signalling: there is no valid/ready pair here. Every control input is a
// level sampled on each rising clk edge and acts only in the cycle it is
// high; every flush output is a same-cycle strobe that the pipeline
// registers consume at the following edge. Nothing is held or retried.
// ---------------------------------------------------------------------------
interface control_pc_if
   import pipeline_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic            start;
   logic            stall;
   logic            jump;
   logic [PC_W-1:0] jump_target;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            halt_id;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus1;
   logic            fetch_valid;
   logic            flush_if_id;
   logic            flush_id_ex;
   logic            halted;
   logic [15:0]     fetch_count;
   state_t          dbg_state;

   modport master (
      output start, stall, jump, jump_target, branch_taken, branch_target, halt_id,
      input  pc, pc_plus1, fetch_valid, flush_if_id, flush_id_ex, halted,
             fetch_count, dbg_state
   );

   modport slave (
      input  start, stall, jump, jump_target, branch_taken, branch_target, halt_id,
      output pc, pc_plus1, fetch_valid, flush_if_id, flush_id_ex, halted,
             fetch_count, dbg_state
   );
endinterface

// File: rtl/sumador.sv
// ---------------------------------------------------------------------------
// sumador
// PC incrementer: sum_o = a_i + 1, wrapping modulo 2^W with no carry out.
//   a_i   : W-bit operand
//   sum_o : W-bit incremented value
// ---------------------------------------------------------------------------
module sumador #(
   parameter int W = 7
) (
   input  logic [W-1:0] a_i,
   output logic [W-1:0] sum_o
);
   assign sum_o = a_i + W'(1);
endmodule

// File: rtl/control_pc.sv
// ---------------------------------------------------------------------------
// control_pc
// Program-counter sequencer for the 5-stage pipeline. Holds the PC, picks
// the next fetch address (increment / ID jump / EX branch / hold), raises the
// IF/ID and ID/EX flush strobes and sequences IDLE -> RUN -> HALT.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : control_pc_if.slave (control inputs in, pc/flush/status out)
// ---------------------------------------------------------------------------
module control_pc
   import pipeline_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic        clk,
   input  logic        rst_n,
   control_pc_if.slave bus
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [PC_W-1:0] pc_plus1;
   pc_src_t         src;
   logic            flush_if;
   logic            flush_ex;

   sumador #(.W(PC_W)) u_inc (
      .a_i   (pc_q),
      .sum_o (pc_plus1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      src      = SRC_HOLD;
      flush_if = 1'b0;
      flush_ex = 1'b0;
      case (state_q)
         IDLE: begin
            pc_d = RESET_PC;
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            // An EX branch is older than anything in ID/IF, so it overrides
            // jump, halt and stall, which all belong to squashed instructions.
            if (bus.branch_taken) begin
               src      = SRC_BR;
               flush_if = 1'b1;
               flush_ex = 1'b1;
            end else if (bus.jump) begin
               src      = SRC_JMP;
               flush_if = 1'b1;
            end else if (bus.halt_id) begin
               state_d  = HALT;
               flush_if = 1'b1;
            end else if (!bus.stall) begin
               src = SRC_INC;
            end
            case (src)
               SRC_INC: pc_d = pc_plus1;
               SRC_JMP: pc_d = bus.jump_target;
               SRC_BR:  pc_d = bus.branch_target;
               default: pc_d = pc_q;
            endcase
            // Every PC load counts as an advance, including a redirect to
            // the current address.
            if (src != SRC_HOLD) cnt_d = sat_inc16(cnt_q);
         end
         HALT: begin
            if (bus.start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = RESET_PC;
         end
      endcase
   end

   // Flushes are only raised from RUN, so reset (which forces IDLE) also
   // drives every combinational output to its inactive value.
   assign bus.pc          = pc_q;
   assign bus.pc_plus1    = pc_plus1;
   assign bus.flush_if_id = flush_if;
   assign bus.flush_id_ex = flush_ex;
   assign bus.fetch_valid = (state_q == RUN) && !flush_if;
   assign bus.halted      = (state_q == HALT);
   assign bus.fetch_count = cnt_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_control_pc.sv
module tb_control_pc;
   import pipeline_pkg::*;

   localparam int PC_W  = 7;
   localparam int NPC   = 128;
   localparam int RST_PC = 0;

   logic clk;
   logic rst_n;

   int n_tests;
   int n_fail;

   // Reference model: plain arithmetic on the architectural state.
   bit m_run;
   bit m_halted;
   int m_pc;
   int m_cnt;

   control_pc_if #(.PC_W(PC_W)) bus ();

   control_pc #(.PC_W(PC_W), .RESET_PC(7'(RST_PC))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run    = 1'b0;
      m_halted = 1'b0;
      m_pc     = RST_PC;
      m_cnt    = 0;
   endtask

   task automatic set_inputs(input bit s, input bit st, input bit j, input logic [6:0] jt,
                             input bit b, input logic [6:0] bt, input bit h);
      bus.start         = s;
      bus.stall         = st;
      bus.jump          = j;
      bus.jump_target   = jt;
      bus.branch_taken  = b;
      bus.branch_target = bt;
      bus.halt_id       = h;
   endtask

   // One clock cycle: drive, check same-cycle strobes, clock, check state.
   task automatic step(input bit s, input bit st, input bit j, input logic [6:0] jt,
                       input bit b, input logic [6:0] bt, input bit h);
      bit e_fif;
      bit e_fex;
      set_inputs(s, st, j, jt, b, bt, h);
      #1;
      e_fif = m_run && (b || j || h);
      e_fex = m_run && b;
      chk("flush_if_id", 32'(bus.flush_if_id), 32'(e_fif));
      chk("flush_id_ex", 32'(bus.flush_id_ex), 32'(e_fex));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_run && !e_fif));
      chk("pc_plus1",    32'(bus.pc_plus1),    32'((m_pc + 1) % NPC));
      @(posedge clk);
      #1;
      if (!m_run) begin
         if (s) begin
            m_run    = 1'b1;
            m_halted = 1'b0;
            m_pc     = RST_PC;
            m_cnt    = 0;
         end
      end else if (b) begin
         m_pc = int'(bt);
         if (m_cnt < 65535) m_cnt++;
      end else if (j) begin
         m_pc = int'(jt);
         if (m_cnt < 65535) m_cnt++;
      end else if (h) begin
         m_run    = 1'b0;
         m_halted = 1'b1;
      end else if (!st) begin
         m_pc = (m_pc + 1) % NPC;
         if (m_cnt < 65535) m_cnt++;
      end
      chk("pc",          32'(bus.pc),          32'(m_pc));
      chk("halted",      32'(bus.halted),      32'(m_halted));
      chk("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
   endtask

   task automatic plain();
      step(0, 0, 0, 7'd0, 0, 7'd0, 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      set_inputs(0, 0, 0, 7'd0, 0, 7'd0, 0);
      model_reset();
      rst_n = 1'b0;
      #12;
      // Reset state
      chk("rst_pc",          32'(bus.pc),          32'(RST_PC));
      chk("rst_halted",      32'(bus.halted),      32'd0);
      chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rst_count",       32'(bus.fetch_count), 32'd0);
      chk("rst_state_idle",  32'(bus.dbg_state),   32'(IDLE));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // IDLE ignores everything but start
      step(0, 1, 1, 7'd9, 1, 7'd33, 1);
      plain();

      // Start then 5 sequential fetches
      step(1, 0, 0, 7'd0, 0, 7'd0, 0);
      for (int i = 0; i < 5; i++) plain();
      chk("seq_pc5",    32'(bus.pc),          32'd5);
      chk("seq_count5", 32'(bus.fetch_count), 32'd5);

      // Wrap at the top of the address space
      step(0, 0, 0, 7'd0, 1, 7'd126, 0);
      for (int i = 0; i < 3; i++) plain();
      chk("wrap_pc", 32'(bus.pc), 32'd1);

      // Branch beats jump and stall
      step(0, 0, 1, 7'd10, 0, 7'd0, 0);
      step(0, 1, 1, 7'd60, 1, 7'd40, 0);
      chk("br_pc40", 32'(bus.pc), 32'd40);
      plain();

      // Jump beats stall, then a 3-cycle stall holds
      step(0, 0, 1, 7'd20, 0, 7'd0, 0);
      step(0, 1, 1, 7'd5, 0, 7'd0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 7'd0, 0, 7'd0, 0);
      chk("stall_pc5", 32'(bus.pc), 32'd5);

      // Branch with halt: stays in RUN
      step(0, 0, 0, 7'd0, 1, 7'd77, 1);
      chk("br_halt_run", 32'(bus.dbg_state), 32'(RUN));

      // Halt at 30, then ignore everything for 10 cycles
      step(0, 0, 1, 7'd30, 0, 7'd0, 0);
      step(0, 0, 0, 7'd0, 0, 7'd0, 1);
      for (int i = 0; i < 10; i++)
         step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom),
              1'(i % 2), 7'($urandom), 1'($urandom_range(0, 1)));
      chk("halt_pc30", 32'(bus.pc), 32'd30);
      step(1, 0, 0, 7'd0, 0, 7'd0, 0);
      chk("restart_pc",    32'(bus.pc),          32'(RST_PC));
      chk("restart_count", 32'(bus.fetch_count), 32'd0);
      chk("restart_state", 32'(bus.dbg_state),   32'(RUN));

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit s;
         s = ($urandom_range(0, 19) == 0) || (m_halted && $urandom_range(0, 3) == 0);
         step(s, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 7'($urandom),
              $urandom_range(0, 6) == 0, 7'($urandom), $urandom_range(0, 19) == 0);
      end

      // Asynchronous reset in the middle of a branch cycle
      if (!m_run) step(1, 0, 0, 7'd0, 0, 7'd0, 0);
      set_inputs(0, 0, 0, 7'd0, 1, 7'd50, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_pc",       32'(bus.pc),          32'(RST_PC));
      chk("arst_flush_if", 32'(bus.flush_if_id), 32'd0);
      chk("arst_flush_ex", 32'(bus.flush_id_ex), 32'd0);
      chk("arst_fv",       32'(bus.fetch_valid), 32'd0);
      chk("arst_state",    32'(bus.dbg_state),   32'(IDLE));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_inputs(0, 0, 0, 7'd0, 0, 7'd0, 0);
      plain();
      plain();

      // Saturation of the advance counter
      step(1, 0, 0, 7'd0, 0, 7'd0, 0);
      set_inputs(0, 0, 0, 7'd0, 0, 7'd0, 0);
      repeat (70000) @(posedge clk);
      #1;
      m_pc  = (m_pc + 70000) % NPC;
      m_cnt = (m_cnt + 70000 > 65535) ? 65535 : m_cnt + 70000;
      chk("sat_count", 32'(bus.fetch_count), 32'(m_cnt));
      chk("sat_pc",    32'(bus.pc),          32'(m_pc));
      plain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
